ldlt_sched: RTL and testbench

Loop-index scheduler for the fixed-point LDLᵀ factorization datapath. On a start pulse it walks the row/column/inner-product index space (i, j, k) of a MAT_DIM×MAT_DIM symmetric matrix in the factorization order. For each step it issues one opcode-tagged command to the arithmetic datapath over a valid/ready handshake, then signals completion. It replaces hard-wired index counters in the datapath, so backpressure from a multi-cycle divider or memory can stall the sequence.

---
 rtl/ldlt_sched.sv | 171 +++++++++++++++++
 tb/tb_ldlt_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ldlt_sched.sv
// Index scheduler for the LDL^T factorization datapath: walks (i, j, k) in
// factorization order and issues one DIV0/ACC/FIN command per handshake.
module ldlt_sched #(
   parameter int MAT_DIM = 600,
   parameter int IDX_W   = 10,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_cmd_valid,
   input  logic             i_cmd_ready,
   output logic [1:0]       o_cmd_op,
   output logic [IDX_W-1:0] o_cmd_i,
   output logic [IDX_W-1:0] o_cmd_j,
   output logic [IDX_W-1:0] o_cmd_k,
   output logic             o_cmd_last,
   output logic [CNT_W-1:0] o_cmd_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [1:0]       OP_DIV0 = 2'd0;
   localparam logic [1:0]       OP_ACC  = 2'd1;
   localparam logic [1:0]       OP_FIN  = 2'd2;
   localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);
   localparam logic [IDX_W-1:0] LAST_I  = IDX_W'(MAT_DIM - 1);
   localparam logic [IDX_W-1:0] LAST_J  = IDX_W'(MAT_DIM - 2);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             valid_q, valid_d;
   logic [1:0]       op_q, op_d;
   logic [IDX_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] ni, nj, nk;

   // j==0 is the row's divide; otherwise the final k of an inner loop is FIN.
   function automatic logic [1:0] op_of(input logic [IDX_W-1:0] j, input logic [IDX_W-1:0] k);
      if (j == '0)
         return OP_DIV0;
      else if (k + ONE < j)
         return OP_ACC;
      else
         return OP_FIN;
   endfunction

   function automatic logic last_of(input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] j,
                                    input logic [IDX_W-1:0] k);
      return (i == LAST_I) && (j == LAST_J) && ((j == '0) || (k + ONE == j));
   endfunction

   always_comb begin
      ni = i_q;
      nj = j_q;
      nk = '0;
      if (k_q + ONE < j_q) begin
         nk = k_q + ONE;
      end else if (j_q + ONE < i_q) begin
         nj = j_q + ONE;
      end else begin
         ni = i_q + ONE;
         nj = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      op_d    = op_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               cnt_d  = '0;
               busy_d = 1'b1;
               if (MAT_DIM == 1) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_RUN;
                  valid_d = 1'b1;
                  i_d     = ONE;
                  j_d     = '0;
                  k_d     = '0;
                  op_d    = OP_DIV0;
                  last_d  = last_of(ONE, '0, '0);
               end
            end
         end
         S_RUN: begin
            if (valid_q && i_cmd_ready) begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
               if (last_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  valid_d = 1'b0;
                  op_d    = OP_DIV0;
                  i_d     = '0;
                  j_d     = '0;
                  k_d     = '0;
                  last_d  = 1'b0;
               end else begin
                  i_d    = ni;
                  j_d    = nj;
                  k_d    = nk;
                  op_d   = op_of(nj, nk);
                  last_d = last_of(ni, nj, nk);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         op_q    <= OP_DIV0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         op_q    <= op_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_cmd_valid = valid_q;
   assign o_cmd_op    = op_q;
   assign o_cmd_i     = i_q;
   assign o_cmd_j     = j_q;
   assign o_cmd_k     = k_q;
   assign o_cmd_last  = last_q;
   assign o_cmd_cnt   = cnt_q;

endmodule

// File: tb/tb_ldlt_sched.sv
// Directed bench for ldlt_sched: MAT_DIM 4 and 8 share a sequence checker,
// MAT_DIM 1 and 2 are checked inline.
module tb_ldlt_sched;
   localparam int IDX_W = 10;
   localparam int CNT_W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic sel8, start, ready, start1, start2, ready2;

   logic b4, d4, v4, l4, b8, d8, v8, l8, b1, d1, v1, l1, b2, d2, v2, l2;
   logic [1:0] op4, op8, op1, op2;
   logic [IDX_W-1:0] i4, j4, k4, i8, j8, k8, i1, j1, k1, i2, j2, k2;
   logic [CNT_W-1:0] c4, c8, c1, c2;

   ldlt_sched #(.MAT_DIM(4), .IDX_W(IDX_W), .CNT_W(CNT_W)) u4 (
      .clk(clk), .rst(rst), .i_start(start & ~sel8), .o_busy(b4), .o_done(d4),
      .o_cmd_valid(v4), .i_cmd_ready(ready & ~sel8), .o_cmd_op(op4), .o_cmd_i(i4),
      .o_cmd_j(j4), .o_cmd_k(k4), .o_cmd_last(l4), .o_cmd_cnt(c4));
   ldlt_sched #(.MAT_DIM(8), .IDX_W(IDX_W), .CNT_W(CNT_W)) u8 (
      .clk(clk), .rst(rst), .i_start(start & sel8), .o_busy(b8), .o_done(d8),
      .o_cmd_valid(v8), .i_cmd_ready(ready & sel8), .o_cmd_op(op8), .o_cmd_i(i8),
      .o_cmd_j(j8), .o_cmd_k(k8), .o_cmd_last(l8), .o_cmd_cnt(c8));
   ldlt_sched #(.MAT_DIM(1), .IDX_W(IDX_W), .CNT_W(CNT_W)) u1 (
      .clk(clk), .rst(rst), .i_start(start1), .o_busy(b1), .o_done(d1),
      .o_cmd_valid(v1), .i_cmd_ready(1'b1), .o_cmd_op(op1), .o_cmd_i(i1),
      .o_cmd_j(j1), .o_cmd_k(k1), .o_cmd_last(l1), .o_cmd_cnt(c1));
   ldlt_sched #(.MAT_DIM(2), .IDX_W(IDX_W), .CNT_W(CNT_W)) u2 (
      .clk(clk), .rst(rst), .i_start(start2), .o_busy(b2), .o_done(d2),
      .o_cmd_valid(v2), .i_cmd_ready(ready2), .o_cmd_op(op2), .o_cmd_i(i2),
      .o_cmd_j(j2), .o_cmd_k(k2), .o_cmd_last(l2), .o_cmd_cnt(c2));

   logic ob_busy, ob_done, ob_valid;
   logic [32:0] ob_cmd, cmd4, cmd1, cmd2;
   logic [CNT_W-1:0] ob_cnt;
   assign cmd4     = {op4, i4, j4, k4, l4};
   assign cmd1     = {op1, i1, j1, k1, l1};
   assign cmd2     = {op2, i2, j2, k2, l2};
   assign ob_busy  = sel8 ? b8 : b4;
   assign ob_done  = sel8 ? d8 : d4;
   assign ob_valid = sel8 ? v8 : v4;
   assign ob_cnt   = sel8 ? c8 : c4;
   assign ob_cmd   = sel8 ? {op8, i8, j8, k8, l8} : cmd4;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [32:0] mk(input int op, input int i, input int j, input int k,
                                      input int last);
      return {2'(op), 10'(i), 10'(j), 10'(k), 1'(last)};
   endfunction

   // Drives one run on the selected instance; stops early when idx reaches abort_at.
   task automatic run_seq(input string nm, input bit rnd, input int abort_at, input bit hold);
      int idx, stall, cyc, n;
      bit aborted;
      idx = 0; stall = 0; cyc = 0; aborted = 0;
      n = exp_q.size();
      @(negedge clk);
      start = 1'b1;
      ready = 1'b0;
      @(negedge clk);
      if (!hold) start = 1'b0;
      check({nm, ":busy_at_start"}, 64'(ob_busy), 64'(1));
      while (idx < n && cyc < 1000) begin
         cyc++;
         check({nm, ":valid"}, 64'(ob_valid), 64'(1));
         check({nm, ":cmd"}, 64'(ob_cmd), 64'(exp_q[idx]));
         check({nm, ":cnt_run"}, 64'(ob_cnt), 64'(idx));
         if (idx == abort_at) begin
            aborted = 1;
            break;
         end
         if (rnd) begin
            if (stall > 0) begin
               ready = 1'b0;
               stall--;
            end else begin
               ready = 1'b1;
               stall = $urandom_range(0, 5);
            end
         end else begin
            ready = 1'b1;
         end
         if (hold && idx == n - 1) start = 1'b0;
         if (ready) idx++;
         @(negedge clk);
      end
      if (!aborted) begin
         check({nm, ":finished_in_budget"}, 64'(idx), 64'(n));
         if (!rnd) check({nm, ":no_bubbles"}, 64'(cyc), 64'(n));
         ready = 1'b0;
         start = 1'b0;
         check({nm, ":done_pulse"}, 64'(ob_done), 64'(1));
         check({nm, ":busy_in_done"}, 64'(ob_busy), 64'(1));
         check({nm, ":valid_dropped"}, 64'(ob_valid), 64'(0));
         check({nm, ":idle_fields"}, 64'(ob_cmd), 64'(0));
         check({nm, ":cnt_final"}, 64'(ob_cnt), 64'(n));
         @(negedge clk);
         check({nm, ":done_fell"}, 64'(ob_done), 64'(0));
         check({nm, ":busy_fell"}, 64'(ob_busy), 64'(0));
         check({nm, ":cnt_hold"}, 64'(ob_cnt), 64'(n));
      end
   endtask

   initial begin
      logic [32:0] tmp;
      sel8 = 1'b0; start = 1'b0; ready = 1'b0;
      start1 = 1'b0; start2 = 1'b0; ready2 = 1'b0;
      #1;
      check("reset_busy", 64'(b4), 64'(0));
      check("reset_done", 64'(d4), 64'(0));
      check("reset_valid", 64'(v4), 64'(0));
      check("reset_fields", 64'(cmd4), 64'(0));
      check("reset_cnt", 64'(c4), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // MAT_DIM=4 hand-derived sequence
      exp_q = {};
      exp_q.push_back(mk(0, 1, 0, 0, 0));
      exp_q.push_back(mk(0, 2, 0, 0, 0));
      exp_q.push_back(mk(2, 2, 1, 0, 0));
      exp_q.push_back(mk(0, 3, 0, 0, 0));
      exp_q.push_back(mk(2, 3, 1, 0, 0));
      exp_q.push_back(mk(1, 3, 2, 0, 0));
      exp_q.push_back(mk(2, 3, 2, 1, 1));
      run_seq("d4_ready", 1'b0, -1, 1'b0);
      run_seq("d4_stall", 1'b1, -1, 1'b0);

      // Abort with reset while the 3rd command is on the bus
      run_seq("d4_abort", 1'b0, 2, 1'b0);
      ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("abort_valid", 64'(v4), 64'(0));
      check("abort_busy", 64'(b4), 64'(0));
      check("abort_fields", 64'(cmd4), 64'(0));
      check("abort_cnt", 64'(c4), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("abort_no_done", 64'(d4), 64'(0));
      end
      run_seq("d4_after_abort", 1'b0, -1, 1'b0);

      // MAT_DIM=8 against a loop model of the factorization order
      sel8 = 1'b1;
      exp_q = {};
      for (int i = 1; i < 8; i++) begin
         exp_q.push_back(mk(0, i, 0, 0, 0));
         for (int j = 1; j < i; j++)
            for (int k = 0; k < j; k++)
               exp_q.push_back(mk((k == j - 1) ? 2 : 1, i, j, k, 0));
      end
      tmp = exp_q[exp_q.size() - 1];
      tmp[0] = 1'b1;
      exp_q[exp_q.size() - 1] = tmp;
      check("d8_model_size", 64'(exp_q.size()), 64'(63));
      run_seq("d8_hold_start", 1'b0, -1, 1'b1);
      run_seq("d8_back2back", 1'b1, -1, 1'b0);
      sel8 = 1'b0;

      // MAT_DIM=1: no commands, single busy cycle with done
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("d1_busy", 64'(b1), 64'(1));
      check("d1_done", 64'(d1), 64'(1));
      check("d1_valid", 64'(v1), 64'(0));
      @(negedge clk);
      check("d1_busy_fell", 64'(b1), 64'(0));
      check("d1_done_fell", 64'(d1), 64'(0));
      check("d1_cnt", 64'(c1), 64'(0));

      // MAT_DIM=2: single DIV0 that is also last
      start2 = 1'b1;
      ready2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      check("d2_valid", 64'(v2), 64'(1));
      check("d2_cmd", 64'(cmd2), 64'(mk(0, 1, 0, 0, 1)));
      @(negedge clk);
      ready2 = 1'b0;
      check("d2_done", 64'(d2), 64'(1));
      check("d2_valid_dropped", 64'(v2), 64'(0));
      check("d2_cnt", 64'(c2), 64'(1));
      @(negedge clk);
      check("d2_done_fell", 64'(d2), 64'(0));
      check("d2_busy_fell", 64'(b2), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
